// File: rtl/risc_debug_pkg.sv
// Shared types and default timing constants for the debug capture/display path.
package risc_debug_pkg;

  typedef enum logic [1:0] {
    MODE_HALT = 2'b00,
    MODE_STEP = 2'b01,
    MODE_SLOW = 2'b10,
    MODE_FULL = 2'b11
  } run_mode_t;

  // 20 ms button settle time and 4 Hz slow-run rate at a 50 MHz system clock
  localparam int DEFAULT_DEBOUNCE_CYCLES = 1_000_000;
  localparam int DEFAULT_SLOW_DIV        = 12_500_000;

endpackage

// File: rtl/debounce_edge.sv
// Synchronizes and debounces a raw push-button, then emits a one-cycle pulse
// on each rising edge of the settled level.
module debounce_edge
  import risc_debug_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = DEFAULT_DEBOUNCE_CYCLES
) (
  input  logic clock,
  input  logic reset_n,
  input  logic btn_raw,
  output logic rise
);

  localparam int CNT_W = $clog2(DEBOUNCE_CYCLES + 1);

  logic             sync_p0;
  logic             sync_p1;
  logic             level;
  logic             level_q;
  logic [CNT_W-1:0] stable_cnt;

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      sync_p0    <= 1'b0;
      sync_p1    <= 1'b0;
      level      <= 1'b0;
      level_q    <= 1'b0;
      stable_cnt <= '0;
    end else begin
      sync_p0 <= btn_raw;
      sync_p1 <= sync_p0;
      level_q <= level;
      // Level only moves after an unbroken run of disagreeing samples
      if (sync_p1 == level) begin
        stable_cnt <= '0;
      end else if (stable_cnt == CNT_W'(DEBOUNCE_CYCLES - 1)) begin
        level      <= sync_p1;
        stable_cnt <= '0;
      end else begin
        stable_cnt <= stable_cnt + CNT_W'(1);
      end
    end
  end

  assign rise = level & ~level_q;

endmodule

// File: rtl/risc_debug_capture.sv
// Core execution control (halt/step/slow/full) and post-cycle snapshot of the
// core's observable state for the debug display.
module risc_debug_capture
  import risc_debug_pkg::*;
#(
  parameter int WIDTH           = 32,
  parameter int DEBOUNCE_CYCLES = DEFAULT_DEBOUNCE_CYCLES,
  parameter int SLOW_DIV        = DEFAULT_SLOW_DIV
) (
  input  logic             clock,
  input  logic             reset_n,
  input  run_mode_t        mode,
  input  logic             step_btn,
  input  logic             freeze,
  input  logic [WIDTH-1:0] core_pc,
  input  logic [WIDTH-1:0] core_instruction,
  input  logic [WIDTH-1:0] core_alu_result,
  input  logic [WIDTH-1:0] core_reg_data1,
  input  logic [WIDTH-1:0] core_reg_data2,
  input  logic [WIDTH-1:0] core_mem_data,
  output logic             core_clk_en,
  output logic [WIDTH-1:0] dbg_pc,
  output logic [WIDTH-1:0] dbg_instruction,
  output logic [WIDTH-1:0] dbg_alu_result,
  output logic [WIDTH-1:0] dbg_reg_data1,
  output logic [WIDTH-1:0] dbg_reg_data2,
  output logic [WIDTH-1:0] dbg_mem_data,
  output logic [31:0]      dbg_cycle_count,
  output logic             snapshot_valid,
  output logic             halted
);

  localparam int DIV_W = $clog2(SLOW_DIV);

  logic             step_rise;
  logic             clk_en_nxt;
  logic             cap_pend;
  logic             div_wrap;
  logic [DIV_W-1:0] div_cnt;

  debounce_edge #(
    .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
  ) u_step_btn (
    .clock   (clock),
    .reset_n (reset_n),
    .btn_raw (step_btn),
    .rise    (step_rise)
  );

  assign div_wrap = (div_cnt == DIV_W'(SLOW_DIV - 1));
  assign halted   = (mode == MODE_HALT) || (mode == MODE_STEP);

  // Step presses seen outside STEP mode simply fall through here
  always_comb begin
    clk_en_nxt = 1'b0;
    case (mode)
      MODE_HALT: clk_en_nxt = 1'b0;
      MODE_STEP: clk_en_nxt = step_rise;
      MODE_SLOW: clk_en_nxt = div_wrap;
      MODE_FULL: clk_en_nxt = 1'b1;
      default:   clk_en_nxt = 1'b0;
    endcase
  end

  // Stage 0 -> 1: clock-enable issue; stage 1 -> 2: capture pending
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      div_cnt         <= '0;
      core_clk_en     <= 1'b0;
      cap_pend        <= 1'b0;
      snapshot_valid  <= 1'b0;
      dbg_cycle_count <= '0;
    end else begin
      if ((mode != MODE_SLOW) || div_wrap) begin
        div_cnt <= '0;
      end else begin
        div_cnt <= div_cnt + DIV_W'(1);
      end
      core_clk_en    <= clk_en_nxt;
      cap_pend       <= core_clk_en;
      snapshot_valid <= cap_pend & ~freeze;
      if (core_clk_en) begin
        dbg_cycle_count <= dbg_cycle_count + 32'd1;
      end
    end
  end

  // Stage 2: snapshot registers, loaded one cycle after the enabled core edge
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      dbg_pc          <= '0;
      dbg_instruction <= '0;
      dbg_alu_result  <= '0;
      dbg_reg_data1   <= '0;
      dbg_reg_data2   <= '0;
      dbg_mem_data    <= '0;
    end else if (cap_pend && !freeze) begin
      dbg_pc          <= core_pc;
      dbg_instruction <= core_instruction;
      dbg_alu_result  <= core_alu_result;
      dbg_reg_data1   <= core_reg_data1;
      dbg_reg_data2   <= core_reg_data2;
      dbg_mem_data    <= core_mem_data;
    end
  end

endmodule

// File: tb/tb_risc_debug_capture.sv
// Scoreboard bench for risc_debug_capture: a cycle model predicts enables and
// snapshots, a separate monitor pops expected snapshots as the DUT presents them.
module tb_risc_debug_capture;
  import risc_debug_pkg::*;

  localparam int W    = 32;
  localparam int DEB  = 4;
  localparam int SDIV = 5;

  logic      clock   = 1'b0;
  logic      reset_n = 1'b1;
  run_mode_t mode    = MODE_HALT;
  logic      step_btn = 1'b0;
  logic      freeze   = 1'b0;
  logic [W-1:0] core_pc = '0, core_instruction = '0, core_alu_result = '0;
  logic [W-1:0] core_reg_data1 = '0, core_reg_data2 = '0, core_mem_data = '0;

  logic         core_clk_en, snapshot_valid, halted;
  logic [W-1:0] dbg_pc, dbg_instruction, dbg_alu_result;
  logic [W-1:0] dbg_reg_data1, dbg_reg_data2, dbg_mem_data;
  logic [31:0]  dbg_cycle_count;

  risc_debug_capture #(.WIDTH(W), .DEBOUNCE_CYCLES(DEB), .SLOW_DIV(SDIV)) dut (
    .clock(clock), .reset_n(reset_n), .mode(mode), .step_btn(step_btn), .freeze(freeze),
    .core_pc(core_pc), .core_instruction(core_instruction), .core_alu_result(core_alu_result),
    .core_reg_data1(core_reg_data1), .core_reg_data2(core_reg_data2), .core_mem_data(core_mem_data),
    .core_clk_en(core_clk_en), .dbg_pc(dbg_pc), .dbg_instruction(dbg_instruction),
    .dbg_alu_result(dbg_alu_result), .dbg_reg_data1(dbg_reg_data1), .dbg_reg_data2(dbg_reg_data2),
    .dbg_mem_data(dbg_mem_data), .dbg_cycle_count(dbg_cycle_count),
    .snapshot_valid(snapshot_valid), .halted(halted)
  );

  always #5 clock = ~clock;

  int checks = 0;
  int errors = 0;
  int cyc    = 0;
  always @(posedge clock) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [W-1:0] act, input logic [W-1:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s got %h want %h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  typedef struct {
    logic [W-1:0] pc, ins, alu, r1, r2, mem;
    int           due;
  } snap_t;

  snap_t sb[$];
  snap_t last;
  snap_t ent;

  function automatic snap_t zero_snap();
    snap_t z;
    z.pc = '0; z.ins = '0; z.alu = '0; z.r1 = '0; z.r2 = '0; z.mem = '0; z.due = 0;
    return z;
  endfunction

  // Reference model: state as seen during the current cycle
  bit          en_m, cap_m, sv_m, db_m, db_prev_m;
  logic [31:0] cnt_m;
  int          slow_age;
  bit          raw_hist[$];
  bit          win[$];

  function automatic void model_reset();
    en_m = 0; cap_m = 0; sv_m = 0; db_m = 0; db_prev_m = 0;
    cnt_m = '0; slow_age = 0;
    raw_hist.delete(); raw_hist.push_back(1'b0); raw_hist.push_back(1'b0);
    win.delete();
    sb.delete();
  endfunction

  always @(negedge clock) begin
    bit s, rise, flip, en_n;
    if (!reset_n) begin
      model_reset();
      chk("rst_clk_en", core_clk_en, 0);
      chk("rst_cycles", dbg_cycle_count, 0);
      chk("rst_valid", snapshot_valid, 0);
      chk("rst_halted", halted, (mode == MODE_HALT || mode == MODE_STEP));
    end else begin
      chk("clk_en", core_clk_en, en_m);
      chk("cycles", dbg_cycle_count, cnt_m);
      chk("snap_valid", snapshot_valid, sv_m);
      chk("halted", halted, (mode == MODE_HALT || mode == MODE_STEP));
      // button: two cycles of synchronizer delay, then a settle window of DEB samples
      raw_hist.push_back(step_btn);
      s = raw_hist.pop_front();
      win.push_back(s);
      if (win.size() > DEB) void'(win.pop_front());
      rise = db_m && !db_prev_m;
      db_prev_m = db_m;
      if (win.size() == DEB) begin
        flip = 1;
        foreach (win[i]) if (win[i] == db_m) flip = 0;
        if (flip) db_m = !db_m;
      end
      if (mode == MODE_STEP)      en_n = rise;
      else if (mode == MODE_SLOW) en_n = ((slow_age % SDIV) == SDIV - 1);
      else if (mode == MODE_FULL) en_n = 1;
      else                        en_n = 0;
      slow_age = (mode == MODE_SLOW) ? slow_age + 1 : 0;
      if (cap_m && !freeze) begin
        ent.pc = core_pc; ent.ins = core_instruction; ent.alu = core_alu_result;
        ent.r1 = core_reg_data1; ent.r2 = core_reg_data2; ent.mem = core_mem_data;
        ent.due = cyc + 1;
        sb.push_back(ent);
      end
      sv_m  = cap_m && !freeze;
      cnt_m = cnt_m + 32'(en_m);
      cap_m = en_m;
      en_m  = en_n;
    end
  end

  // Monitor: consumes one expected snapshot per snapshot_valid, otherwise expects hold
  always @(negedge clock) begin
    if (!reset_n) begin
      last = zero_snap();
    end else begin
      if (snapshot_valid) begin
        if (sb.size() == 0) begin
          checks++; errors++;
          $display("FAIL snap_unexpected got valid=1 want no snapshot (cycle %0d)", cyc);
        end else begin
          last = sb.pop_front();
          chk("snap_due", cyc, last.due);
        end
      end
      chk("dbg_pc", dbg_pc, last.pc);
      chk("dbg_instruction", dbg_instruction, last.ins);
      chk("dbg_alu_result", dbg_alu_result, last.alu);
      chk("dbg_reg_data1", dbg_reg_data1, last.r1);
      chk("dbg_reg_data2", dbg_reg_data2, last.r2);
      chk("dbg_mem_data", dbg_mem_data, last.mem);
    end
  end

  bit           hold_pc = 0;
  logic [W-1:0] prev_alu = '0;

  task automatic step();
    @(posedge clock);
    #1;
    prev_alu = core_alu_result;
    if (!hold_pc) core_pc = $urandom;
    core_instruction = $urandom;
    core_alu_result  = $urandom;
    core_reg_data1   = $urandom;
    core_reg_data2   = $urandom;
    core_mem_data    = $urandom;
  endtask

  initial begin
    logic [31:0]  c0;
    logic [W-1:0] held;
    int           seg, hold;
    #1 reset_n = 1'b0;
    repeat (3) step();
    #2 reset_n = 1'b1;

    mode = MODE_HALT;
    repeat (20) step();
    chk("halt_cycles", dbg_cycle_count, 0);
    chk("halt_halted", halted, 1);
    chk("halt_valid", snapshot_valid, 0);

    mode = MODE_STEP; hold_pc = 1; core_pc = 32'h1004; step_btn = 1'b1;
    repeat (10) step();
    step_btn = 1'b0;
    repeat (10) step();
    chk("step_cycles", dbg_cycle_count, 1);
    chk("step_pc", dbg_pc, 32'h1004);
    hold_pc = 0;

    repeat (4) begin
      step_btn = 1'b1; repeat (3) step();
      step_btn = 1'b0; repeat (3) step();
    end
    chk("bounce_cycles", dbg_cycle_count, 1);

    mode = MODE_HALT; step_btn = 1'b1;
    repeat (10) step();
    mode = MODE_STEP;
    repeat (5) step();
    step_btn = 1'b0;
    repeat (12) step();
    chk("halt_press_cycles", dbg_cycle_count, 1);

    mode = MODE_SLOW;
    c0 = dbg_cycle_count;
    repeat (26) step();
    chk("slow_cycles", dbg_cycle_count - c0, 5);
    mode = MODE_HALT;
    repeat (3) step();

    mode = MODE_FULL;
    repeat (4) step();
    freeze = 1'b1;
    held = prev_alu;
    c0 = dbg_cycle_count;
    repeat (10) step();
    chk("freeze_alu", dbg_alu_result, held);
    chk("freeze_cycles", dbg_cycle_count - c0, 10);
    freeze = 1'b0;
    repeat (10) step();
    chk("track_alu", dbg_alu_result, prev_alu);
    chk("track_valid", snapshot_valid, 1);

    #2 reset_n = 1'b0;
    #1;
    chk("mid_rst_clk_en", core_clk_en, 0);
    chk("mid_rst_cycles", dbg_cycle_count, 0);
    chk("mid_rst_valid", snapshot_valid, 0);
    chk("mid_rst_alu", dbg_alu_result, 0);
    step();
    #2 reset_n = 1'b1;
    repeat (10) step();
    chk("restart_cycles", dbg_cycle_count, 9);

    seg = 0; hold = 0;
    repeat (400) begin
      if (seg == 0) begin
        mode   = run_mode_t'($urandom_range(0, 3));
        freeze = ($urandom_range(0, 3) == 0);
        seg    = $urandom_range(8, 15);
      end
      if (hold == 0) begin
        step_btn = 1'($urandom_range(0, 1));
        hold     = $urandom_range(1, 8);
      end
      seg--; hold--;
      step();
    end

    mode = MODE_HALT; freeze = 1'b0; step_btn = 1'b0;
    repeat (6) step();
    chk("sb_drain", sb.size(), 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/risc_debug_capture.md
# risc_debug_capture

Execution-control and snapshot stage that sits between the RISC-V core and `risc_debug_display`, replacing simulated debug data with live core state. It gates the core through a clock-enable in one of four modes (halt, single-step, slow run, full run). It latches the core's observable signals after every enabled core cycle into stable snapshot registers. It also counts executed core cycles for the display's `clock_counter` field.

## Interface
Parameters:
- `WIDTH`, 32, data width of every captured bus
- `DEBOUNCE_CYCLES`, 1_000_000, consecutive stable cycles required to accept a step-button level change (20 ms at 50 MHz)
- `SLOW_DIV`, 12_500_000, period in clock cycles of `core_clk_en` in slow-run mode (4 Hz); minimum 2

Ports:
- `clock`  in  1  50 MHz system clock
- `reset_n`  in  1  reset, asynchronous and active-low
- `mode`  in  2  `run_mode_t`, run mode select from switches; asynchronous to logic, used directly
- `step_btn`  in  1  raw, bouncy, asynchronous single-step push-button, high = pressed
- `freeze`  in  1  1 = hold snapshot registers; the core keeps running
- `core_pc`, `core_instruction`, `core_alu_result`, `core_reg_data1`, `core_reg_data2`, `core_mem_data`  in  WIDTH  live core signals
- `core_clk_en`  out  1  registered core clock-enable; core advances on a clock edge where it is 1
- `dbg_pc`, `dbg_instruction`, `dbg_alu_result`, `dbg_reg_data1`, `dbg_reg_data2`, `dbg_mem_data`  out  WIDTH  snapshot to display
- `dbg_cycle_count`  out  32  number of enabled core cycles, wraps at 2^32
- `snapshot_valid`  out  1  one-cycle pulse when snapshot registers update
- `halted`  out  1  1 when `mode` is HALT or STEP

## Operation
- Modes:
  - **HALT**: `core_clk_en` = 0.
  - **STEP**: one `core_clk_en` pulse per accepted button press (rising edge of the debounced level). Releases and bounces generate nothing.
  - **SLOW**: divider counter 0..SLOW_DIV-1; `core_clk_en` is 1 in the cycle after the counter reaches SLOW_DIV-1. The divider clears to 0 on every cycle where mode ≠ SLOW, so the first pulse comes SLOW_DIV cycles after entering SLOW.
  - **FULL**: `core_clk_en` = 1 every cycle.
- Button path:
  - 2-FF synchronizer feeds the debouncer.
  - The debounced level flips only after the synchronized input has differed from it for DEBOUNCE_CYCLES consecutive cycles. Any agreeing cycle clears the counter.
  - A rising edge of the debounced level while mode ≠ STEP is discarded; it is not queued.
- Capture:
  - `cap_pend` is the registered copy of `core_clk_en`.
  - On a cycle with `cap_pend` = 1 and `freeze` = 0: all `dbg_*` data registers load the `core_*` inputs, and `snapshot_valid` = 1 the next cycle.
  - With `freeze` = 1, the capture is skipped and `snapshot_valid` stays 0.
- `dbg_cycle_count` increments by 1 on every cycle `core_clk_en` = 1, regardless of `freeze`. It wraps 0xFFFFFFFF → 0.
- `halted` is combinational from `mode`.

## Timing
- Reset (`reset_n` = 0, asynchronous):
  - All `dbg_*`, `dbg_cycle_count`, `core_clk_en`, `snapshot_valid`, the divider, the debounce counter, the synchronizer, the debounced level and `cap_pend` go to 0.
  - Reset mid-step or mid-divide abandons the pulse.
- Step latency: raw rise at cycle t, stable → debounced level high at t+2+DEBOUNCE_CYCLES → `core_clk_en` high at t+3+DEBOUNCE_CYCLES for exactly 1 cycle.
- Capture: `core_clk_en` at cycle n → data registers load at the end of n+1 (inputs sampled after the core update) → `dbg_*` and `snapshot_valid` visible at n+2.
- In FULL mode, a snapshot updates every cycle with 2-cycle lag; `snapshot_valid` stays high continuously.
- Mode change takes effect on the next `core_clk_en` register update. A pulse already in `cap_pend` is still captured.
- Simultaneous `freeze` rise and `cap_pend` = 1: `freeze` wins and there is no capture.

## Structure
- Shared package `risc_debug_pkg`:
  - `typedef enum logic [1:0] run_mode_t {MODE_HALT=2'b00, MODE_STEP=2'b01, MODE_SLOW=2'b10, MODE_FULL=2'b11}`
  - default constants for `DEBOUNCE_CYCLES` and `SLOW_DIV`
- One sub-module, `debounce_edge` (synchronizer + debouncer + rising-edge pulse), parameterized by DEBOUNCE_CYCLES.
- Top level holds the mode logic, divider, cycle counter and snapshot registers.

## Test plan
Bench parameters: DEBOUNCE_CYCLES=4, SLOW_DIV=5.
- Reset then release, mode=HALT, 20 cycles → `core_clk_en` = 0, all outputs 0, `halted` = 1.
- mode=STEP, `core_pc`=0x1004, `step_btn` high 10 cycles → exactly one `core_clk_en` pulse 7 cycles after the press; `dbg_pc`=0x1004 and `snapshot_valid` pulse 2 cycles later; `dbg_cycle_count`=1.
- mode=STEP, `step_btn` toggled high for 3 cycles, low for 3 cycles, repeated → no `core_clk_en`. A press made while mode=HALT, followed by switching to STEP → no pulse.
- mode=SLOW for 26 cycles → pulses at 5-cycle spacing, first at cycle 5 after entry; `dbg_cycle_count`=5.
- mode=FULL, `freeze`=1 for 10 cycles with `core_alu_result` changing → `dbg_alu_result` held, `dbg_cycle_count` +10. Then `freeze`=0 → snapshot tracks the input with 2-cycle lag.
- mode=FULL, `reset_n` asserted mid-cycle for 1 cycle → all outputs 0 immediately; counting restarts from 0 after release.
